// File: rtl/mem_wb_stage_pkg.sv
// Shared decode codes for load types and writeback selection, used by the
// decoder, MEM and WB stages.
package mem_wb_stage_pkg;

   localparam int XLEN_DEF = 32;
   localparam int RFAW_DEF = 5;

   typedef enum logic [2:0] {
      DM_LW  = 3'b000,
      DM_LH  = 3'b001,
      DM_LHU = 3'b010,
      DM_LB  = 3'b011,
      DM_LBU = 3'b100
   } dm_type_e;

   typedef enum logic [1:0] {
      WD_ALU  = 2'b00,
      WD_LOAD = 2'b01,
      WD_PC4  = 2'b10,
      WD_PCC  = 2'b11
   } wd_sel_e;

   // Alignment rule only; gating by valid and WDSel is done by the caller.
   function automatic logic addr_misaligned(input logic [2:0] dmtype,
                                            input logic [1:0] addr);
      logic bad;
      bad = 1'b0;
      if (dmtype == DM_LW)
         bad = (addr != 2'b00);
      else if ((dmtype == DM_LH) || (dmtype == DM_LHU))
         bad = addr[0];
      return bad;
   endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM-side inputs and WB-side registered outputs of the MEM/WB pipeline
// register. Handshake: valid_i qualifies the MEM fields; valid_o qualifies WB.
interface mem_wb_stage_if #(
   parameter int XLEN = 32,
   parameter int RFAW = 5
);
   logic            valid_i;
   logic [XLEN-1:0] C_i;
   logic [XLEN-1:0] dm_rdata_i;
   logic [2:0]      DMType_i;
   logic [XLEN-1:0] PC_i;
   logic [1:0]      WDSel_i;
   logic            RegWrite_i;
   logic [RFAW-1:0] rd_i;

   logic            valid_o;
   logic [XLEN-1:0] C_o;
   logic [XLEN-1:0] readdata_o;
   logic [XLEN-1:0] PC_o;
   logic [1:0]      WDSel_o;
   logic            RegWrite_o;
   logic [RFAW-1:0] rd_o;
   logic            misalign_o;
   logic [31:0]     instret_o;

   modport slave (
      input  valid_i, C_i, dm_rdata_i, DMType_i, PC_i, WDSel_i, RegWrite_i, rd_i,
      output valid_o, C_o, readdata_o, PC_o, WDSel_o, RegWrite_o, rd_o,
             misalign_o, instret_o
   );

   modport master (
      output valid_i, C_i, dm_rdata_i, DMType_i, PC_i, WDSel_i, RegWrite_i, rd_i,
      input  valid_o, C_o, readdata_o, PC_o, WDSel_o, RegWrite_o, rd_o,
             misalign_o, instret_o
   );
endinterface

// File: rtl/mem_wb_stage_load_ext.sv
// Combinational load formatter: picks the byte/half addressed by addr_i from
// the aligned memory word and sign- or zero-extends it.
module load_ext
   import mem_wb_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]      addr_i,
   input  logic [XLEN-1:0] rdata_i,
   input  logic [2:0]      dmtype_i,
   output logic [XLEN-1:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'h00;
      half_sel = 16'h0000;
      case (addr_i)
         2'b00:   byte_sel = rdata_i[7:0];
         2'b01:   byte_sel = rdata_i[15:8];
         2'b10:   byte_sel = rdata_i[23:16];
         default: byte_sel = rdata_i[31:24];
      endcase
      half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   // Unknown load codes fall through to the full word.
   always_comb begin
      data_o = rdata_i;
      case (dmtype_i)
         DM_LH:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
         DM_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
         DM_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         DM_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: formats load data, flags misaligned loads,
// gates register writes and counts retired instructions.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int RFAW = RFAW_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           stall,
   input  logic           flush,
   mem_wb_stage_if.slave  bus
);

   logic [XLEN-1:0] fmt_data;
   logic            misaligned;

   logic            valid_q,    valid_d;
   logic [XLEN-1:0] c_q,        c_d;
   logic [XLEN-1:0] rdata_q,    rdata_d;
   logic [XLEN-1:0] pc_q,       pc_d;
   logic [1:0]      wdsel_q,    wdsel_d;
   logic            regwrite_q, regwrite_d;
   logic [RFAW-1:0] rd_q,       rd_d;
   logic            misalign_q, misalign_d;
   logic [31:0]     instret_q,  instret_d;

   load_ext #(.XLEN(XLEN)) u_load_ext (
      .addr_i   (bus.C_i[1:0]),
      .rdata_i  (bus.dm_rdata_i),
      .dmtype_i (bus.DMType_i),
      .data_o   (fmt_data)
   );

   always_comb begin
      misaligned = (bus.WDSel_i == WD_LOAD) && bus.valid_i &&
                   addr_misaligned(bus.DMType_i, bus.C_i[1:0]);

      valid_d    = bus.valid_i;
      c_d        = bus.C_i;
      rdata_d    = fmt_data;
      pc_d       = bus.PC_i;
      wdsel_d    = bus.WDSel_i;
      regwrite_d = bus.RegWrite_i && bus.valid_i && (bus.rd_i != '0) && !misaligned;
      rd_d       = bus.rd_i;
      misalign_d = misaligned;
      // Misaligned loads trap, so they do not retire.
      instret_d  = (bus.valid_i && !misaligned) ? instret_q + 32'd1 : instret_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= 1'b0;
         c_q        <= '0;
         rdata_q    <= '0;
         pc_q       <= '0;
         wdsel_q    <= '0;
         regwrite_q <= 1'b0;
         rd_q       <= '0;
         misalign_q <= 1'b0;
         instret_q  <= '0;
      end else if (flush) begin
         valid_q    <= 1'b0;
         c_q        <= '0;
         rdata_q    <= '0;
         pc_q       <= '0;
         wdsel_q    <= '0;
         regwrite_q <= 1'b0;
         rd_q       <= '0;
         misalign_q <= 1'b0;
      end else if (!stall) begin
         valid_q    <= valid_d;
         c_q        <= c_d;
         rdata_q    <= rdata_d;
         pc_q       <= pc_d;
         wdsel_q    <= wdsel_d;
         regwrite_q <= regwrite_d;
         rd_q       <= rd_d;
         misalign_q <= misalign_d;
         instret_q  <= instret_d;
      end
   end

   assign bus.valid_o    = valid_q;
   assign bus.C_o        = c_q;
   assign bus.readdata_o = rdata_q;
   assign bus.PC_o       = pc_q;
   assign bus.WDSel_o    = wdsel_q;
   assign bus.RegWrite_o = regwrite_q;
   assign bus.rd_o       = rd_q;
   assign bus.misalign_o = misalign_q;
   assign bus.instret_o  = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: each step pushes its hand-computed WB
// outputs into a queue; a monitor pops one entry after every clock edge.
module tb_mem_wb_stage;

   typedef struct packed {
      logic        rst;
      logic        flush;
      logic        stall;
      logic        valid;
      logic [31:0] c;
      logic [31:0] rdata;
      logic [2:0]  dmt;
      logic [31:0] pc;
      logic [1:0]  wdsel;
      logic        regw;
      logic [4:0]  rd;
   } in_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] c;
      logic [31:0] rdata;
      logic [31:0] pc;
      logic [1:0]  wdsel;
      logic        regw;
      logic [4:0]  rd;
      logic        mis;
      logic [31:0] instret;
   } out_t;

   localparam int OW = $bits(out_t);

   logic clk;
   logic rst;
   logic stall;
   logic flush;
   logic [OW-1:0] exp_q[$];
   int total;
   int bad;

   mem_wb_stage_if #(.XLEN(32), .RFAW(5)) bus ();

   mem_wb_stage #(.XLEN(32), .RFAW(5)) dut (
      .clk   (clk),
      .rst   (rst),
      .stall (stall),
      .flush (flush),
      .bus   (bus.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   function automatic in_t vin(input logic fl, input logic st, input logic v,
                               input logic [31:0] c, input logic [31:0] rdata,
                               input logic [2:0] dmt, input logic [31:0] pc,
                               input logic [1:0] wdsel, input logic regw,
                               input logic [4:0] rd);
      in_t i;
      i.rst = 1'b0; i.flush = fl; i.stall = st; i.valid = v; i.c = c;
      i.rdata = rdata; i.dmt = dmt; i.pc = pc; i.wdsel = wdsel;
      i.regw = regw; i.rd = rd;
      return i;
   endfunction

   function automatic out_t vout(input logic v, input logic [31:0] c,
                                 input logic [31:0] rdata, input logic [31:0] pc,
                                 input logic [1:0] wdsel, input logic regw,
                                 input logic [4:0] rd, input logic mis,
                                 input logic [31:0] instret);
      out_t o;
      o.valid = v; o.c = c; o.rdata = rdata; o.pc = pc; o.wdsel = wdsel;
      o.regw = regw; o.rd = rd; o.mis = mis; o.instret = instret;
      return o;
   endfunction

   // driver: called just after a falling edge; returns after the next one
   task automatic step(input in_t i, input out_t e);
      rst            = i.rst;
      flush          = i.flush;
      stall          = i.stall;
      bus.valid_i    = i.valid;
      bus.C_i        = i.c;
      bus.dm_rdata_i = i.rdata;
      bus.DMType_i   = i.dmt;
      bus.PC_i       = i.pc;
      bus.WDSel_i    = i.wdsel;
      bus.RegWrite_i = i.regw;
      bus.rd_i       = i.rd;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // monitor / scoreboard
   initial begin
      out_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = out_t'(exp_q.pop_front());
            chk("valid_o",    {31'd0, bus.valid_o},    {31'd0, e.valid});
            chk("C_o",        bus.C_o,                 e.c);
            chk("readdata_o", bus.readdata_o,          e.rdata);
            chk("PC_o",       bus.PC_o,                e.pc);
            chk("WDSel_o",    {30'd0, bus.WDSel_o},    {30'd0, e.wdsel});
            chk("RegWrite_o", {31'd0, bus.RegWrite_o}, {31'd0, e.regw});
            chk("rd_o",       {27'd0, bus.rd_o},       {27'd0, e.rd});
            chk("misalign_o", {31'd0, bus.misalign_o}, {31'd0, e.mis});
            chk("instret_o",  bus.instret_o,           e.instret);
         end
      end
   end

   // directed vectors
   initial begin
      in_t  i;
      out_t hold;
      total = 0;
      bad   = 0;
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      bus.valid_i = 1'b0; bus.C_i = '0; bus.dm_rdata_i = '0; bus.DMType_i = '0;
      bus.PC_i = '0; bus.WDSel_i = '0; bus.RegWrite_i = 1'b0; bus.rd_i = '0;
      @(negedge clk);

      i = vin(0, 0, 1, 32'h55, 32'h66, 3'b000, 32'h77, 2'b01, 1, 5'd9);
      i.rst = 1'b1;
      step(i, vout(0, 0, 0, 0, 0, 0, 0, 0, 0));

      step(vin(0, 0, 1, 32'h1003, 32'h80FF_1234, 3'b011, 32'h100, 2'b01, 1, 5'd3),
           vout(1, 32'h1003, 32'hFFFF_FF80, 32'h100, 2'b01, 1, 5'd3, 0, 1));
      step(vin(0, 0, 1, 32'h1002, 32'h8001_7FFF, 3'b010, 32'h104, 2'b01, 1, 5'd4),
           vout(1, 32'h1002, 32'h0000_8001, 32'h104, 2'b01, 1, 5'd4, 0, 2));
      step(vin(0, 0, 1, 32'h1001, 32'h8001_7FFF, 3'b001, 32'h108, 2'b01, 1, 5'd6),
           vout(1, 32'h1001, 32'h0000_7FFF, 32'h108, 2'b01, 0, 5'd6, 1, 2));
      step(vin(0, 0, 1, 32'h1001, 32'h80FF_1234, 3'b100, 32'h10C, 2'b01, 1, 5'd7),
           vout(1, 32'h1001, 32'h0000_0012, 32'h10C, 2'b01, 1, 5'd7, 0, 3));
      step(vin(0, 0, 1, 32'h1004, 32'hDEAD_BEEF, 3'b000, 32'h110, 2'b01, 1, 5'd8),
           vout(1, 32'h1004, 32'hDEAD_BEEF, 32'h110, 2'b01, 1, 5'd8, 0, 4));
      step(vin(0, 0, 1, 32'h1006, 32'hDEAD_BEEF, 3'b000, 32'h114, 2'b01, 1, 5'd8),
           vout(1, 32'h1006, 32'hDEAD_BEEF, 32'h114, 2'b01, 0, 5'd8, 1, 4));

      hold = vout(1, 32'h2A, 32'h1122_3344, 32'h118, 2'b00, 1, 5'd5, 0, 5);
      step(vin(0, 0, 1, 32'h2A, 32'h1122_3344, 3'b000, 32'h118, 2'b00, 1, 5'd5), hold);
      for (int k = 0; k < 3; k++)
         step(vin(0, 1, 1, 32'h99 + k, $urandom, 3'b011, 32'h200 + k, 2'b01, 1, 5'd9), hold);

      step(vin(1, 1, 1, 32'h77, 32'h55, 3'b000, 32'h300, 2'b01, 1, 5'd2),
           vout(0, 0, 0, 0, 2'b00, 0, 5'd0, 0, 5));
      step(vin(0, 0, 1, 32'h7, 32'h0, 3'b000, 32'h11C, 2'b00, 1, 5'd0),
           vout(1, 32'h7, 32'h0, 32'h11C, 2'b00, 0, 5'd0, 0, 6));
      step(vin(0, 0, 0, 32'h55, 32'hAAAA_5555, 3'b000, 32'h120, 2'b01, 1, 5'd3),
           vout(0, 32'h55, 32'hAAAA_5555, 32'h120, 2'b01, 0, 5'd3, 0, 6));
      step(vin(0, 0, 1, 32'h2000, 32'hCAFE_F00D, 3'b111, 32'h124, 2'b01, 1, 5'd10),
           vout(1, 32'h2000, 32'hCAFE_F00D, 32'h124, 2'b01, 1, 5'd10, 0, 7));
      step(vin(0, 0, 1, 32'h3000, 32'h0000_007F, 3'b011, 32'h128, 2'b01, 1, 5'd11),
           vout(1, 32'h3000, 32'h0000_007F, 32'h128, 2'b01, 1, 5'd11, 0, 8));
      step(vin(0, 0, 1, 32'h3000, 32'h1234_F001, 3'b001, 32'h12C, 2'b01, 1, 5'd12),
           vout(1, 32'h3000, 32'hFFFF_F001, 32'h12C, 2'b01, 1, 5'd12, 0, 9));

      hold = vout(1, 32'h3002, 32'h1111_1111, 32'h130, 2'b01, 0, 5'd13, 1, 9);
      step(vin(0, 0, 1, 32'h3002, 32'h1111_1111, 3'b000, 32'h130, 2'b01, 1, 5'd13), hold);
      step(vin(0, 1, 1, 32'h4000, 32'h22, 3'b000, 32'h134, 2'b01, 1, 5'd14), hold);

      i = vin(0, 1, 1, 32'h4000, 32'h22, 3'b000, 32'h134, 2'b01, 1, 5'd14);
      i.rst = 1'b1;
      step(i, vout(0, 0, 0, 0, 0, 0, 0, 0, 0));
      step(vin(0, 0, 1, 32'h40, 32'h1, 3'b000, 32'h138, 2'b01, 1, 5'd1),
           vout(1, 32'h40, 32'h1, 32'h138, 2'b01, 1, 5'd1, 0, 1));

      force dut.instret_q = 32'hFFFF_FFFF;
      #1;
      release dut.instret_q;
      step(vin(0, 0, 1, 32'h44, 32'h0, 3'b000, 32'h13C, 2'b00, 1, 5'd2),
           vout(1, 32'h44, 32'h0, 32'h13C, 2'b00, 1, 5'd2, 0, 0));

      i = vin(0, 0, 1, 32'h48, 32'h5, 3'b000, 32'h140, 2'b00, 1, 5'd2);
      i.rst = 1'b1;
      step(i, vout(0, 0, 0, 0, 0, 0, 0, 0, 0));

      repeat (3) @(posedge clk);
      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
- REQ-001 Parameter: XLEN, default 32, datapath width.
- REQ-002 Parameter: RFAW, default 5, register-index width.
- REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
- REQ-004 Port: rst  in  1  reset, synchronous, active-high.
- REQ-005 Port: stall  in  1  hold all stage contents.
- REQ-006 Port: flush  in  1  insert bubble.
- REQ-007 Port: valid_i  in  1  MEM-stage instruction valid.
- REQ-008 Port: C_i  in  XLEN  ALU result / data-memory address.
- REQ-009 Port: dm_rdata_i  in  XLEN  raw aligned word from data memory.
- REQ-010 Port: DMType_i  in  3  load type: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu.
- REQ-011 Port: PC_i  in  XLEN  instruction PC.
- REQ-012 Port: WDSel_i  in  2  writeback select; 01 means load.
- REQ-013 Port: RegWrite_i  in  1  register-write enable.
- REQ-014 Port: rd_i  in  RFAW  destination register.
- REQ-015 Port: valid_o, C_o, readdata_o, PC_o, WDSel_o, RegWrite_o, rd_o  out  widths as inputs  registered WB-stage fields; readdata_o is formatted load data for the writeback select.
- REQ-016 Port: misalign_o  out  1  one-cycle flag: captured load was misaligned.
- REQ-017 Port: instret_o  out  32  retired-instruction count.

Function
- REQ-018 Latency SHALL be exactly one clock from MEM inputs to WB outputs.
- REQ-019 Priority on each edge SHALL be rst > flush > stall > capture.
- REQ-020 flush SHALL load a bubble: valid_o=0, RegWrite_o=0, misalign_o=0, all data fields 0.
- REQ-021 stall (without flush) SHALL hold every output unchanged, including misalign_o and instret_o.
- REQ-022 Capture SHALL register all fields; RegWrite_o = RegWrite_i & valid_i & (rd_i!=0) & ~misaligned.
- REQ-023 Load formatting SHALL be combinational before the register: lb/lbu select byte C_i[1:0], lh/lhu select half C_i[1]; lb/lh sign-extend, lbu/lhu zero-extend; lw passes the word; undefined DMType codes behave as lw.
- REQ-024 Misaligned SHALL mean WDSel_i==01 & valid_i & ((lw & C_i[1:0]!=0) | ((lh|lhu) & C_i[0])); misalign_o SHALL assert for exactly the captured instruction and clear on the next capture.
- REQ-025 For non-load instructions readdata_o SHALL still carry formatted data; it is don't-care to consumers.
- REQ-026 instret_o SHALL increment by 1 on each capture with valid_i=1 and not misaligned; it SHALL not change on flush, stall or bubble capture; it SHALL wrap 0xFFFFFFFF->0.
- REQ-027 Simultaneous flush and stall SHALL flush.

Reset
- REQ-028 On rst at a rising edge, all outputs SHALL become 0 (valid_o, RegWrite_o, misalign_o, instret_o included) regardless of stall/flush.
- REQ-029 rst mid-stall SHALL discard the held instruction; the first post-reset capture SHALL behave normally.

Structure
- REQ-030 DMType codes and WDSel codes (00 ALU, 01 load, 10 PC+4, 11 PC+C) SHALL live in a shared package used by decoder, MEM and WB stages.
- REQ-031 Load formatting SHALL be one combinational sub-module, load_ext.
- REQ-032 Target size 120-250 lines RTL; no latches; nonblocking assignments for all registers.

Verification
- REQ-033 lb, C_i=0x1003, dm_rdata_i=0x80FF_1234 -> next cycle readdata_o=0xFFFFFF80, RegWrite_o=1, instret_o +1.
- REQ-034 lhu, C_i=0x1002, dm_rdata_i=0x8001_7FFF -> readdata_o=0x00008001; lh, C_i=0x1001 -> misalign_o=1, RegWrite_o=0, instret_o unchanged.
- REQ-035 Capture add (rd=5, C_i=0x2A), then stall 3 cycles with changing inputs -> outputs hold 0x2A/rd 5 for all 3 cycles, instret_o increments once total.
- REQ-036 flush and stall together with valid_i=1 -> valid_o=0, RegWrite_o=0, C_o=0.
- REQ-037 rd_i=0, RegWrite_i=1, valid_i=1 -> RegWrite_o=0, instret_o +1.
- REQ-038 Preload instret_o to 0xFFFFFFFF via 2^32-1 valid captures (or force), one more valid capture -> instret_o=0; then rst -> all outputs 0.
